// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and fetch FSM state type for the CPU front end
//   ADDR_W        : instruction-memory address width
//   INSTR_W       : instruction word width
//   fetch_state_t : IDLE -> ADDR -> CAPTURE -> IDLE fetch sequence
package cpu_pkg;
    localparam int ADDR_W  = 7;
    localparam int INSTR_W = 16;
    typedef enum logic [1:0] {IDLE, ADDR, CAPTURE} fetch_state_t;
endpackage

// File: rtl/program_counter.sv
// program_counter: program counter register with load, wrapping increment and hold
//   clock    : rising-edge clock
//   reset_n  : synchronous active-low reset, clears pc to 0
//   load     : replace pc with load_val
//   load_val : jump/branch target
//   inc      : advance pc by one, wrapping modulo 2^ADDR_W
//   pc       : current program counter
module program_counter #(
    parameter int ADDR_W = cpu_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);
    always_ff @(posedge clock) begin
        if (!reset_n)
            pc <= '0;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + ADDR_W'(1);
    end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: three-state instruction fetch unit driving a synchronous ROM
//   clock, reset_n  : rising-edge clock, synchronous active-low reset
//   fetch_req       : request next instruction (accepted only when idle)
//   pc_load         : load pc from pc_load_val (accepted only when idle)
//   pc_load_val     : jump/branch target
//   rom_addr, rom_q : ROM address (always pc) and its data one edge later
//   ir, ir_valid    : instruction register and its one-cycle new-data pulse
//   pc, busy        : program counter and fetch-in-progress flag
module inst_fetch #(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               fetch_req,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_load_val,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_q,
    output logic [INSTR_W-1:0] ir,
    output logic               ir_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy
);
    import cpu_pkg::*;

    fetch_state_t state;

    program_counter #(.ADDR_W(ADDR_W)) u_pc (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (state == IDLE && pc_load),
        .load_val (pc_load_val),
        .inc      (state == CAPTURE),
        .pc       (pc)
    );

    assign rom_addr = pc;
    assign busy     = state != IDLE;

    // A load and a request on the same idle edge both take effect: the ROM
    // samples rom_addr one edge later, so it sees the freshly loaded pc.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            ir       <= '0;
            ir_valid <= 1'b0;
        end else begin
            ir_valid <= state == CAPTURE;
            if (state == CAPTURE)
                ir <= rom_q;
            case (state)
                IDLE:    state <= fetch_req ? ADDR : IDLE;
                ADDR:    state <= CAPTURE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a transaction-level model
module tb_inst_fetch;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic        pc_load = 1'b0;
    logic [6:0]  pc_load_val = '0;
    logic [6:0]  rom_addr;
    logic [15:0] rom_q = '0;
    logic [15:0] ir;
    logic        ir_valid;
    logic [6:0]  pc;
    logic        busy;

    int checks = 0;
    int failures = 0;

    inst_fetch dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .fetch_req   (fetch_req),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .pc          (pc),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) rom_q <= 16'hA000 | {9'd0, rom_addr};

    // Transaction model: a fetch is a 2-edge countdown from acceptance to the
    // instruction landing; inputs are only honoured while nothing is pending.
    int          m_pc = 0;
    int          m_addr = 0;
    int          m_left = 0;
    logic [15:0] m_ir = '0;
    logic        m_valid = 1'b0;
    logic        m_live = 1'b0;

    always @(posedge clock) begin
        if (!reset_n) begin
            m_pc = 0; m_ir = '0; m_valid = 1'b0; m_left = 0; m_live = 1'b1;
        end else begin
            m_valid = 1'b0;
            if (m_left == 0) begin
                if (pc_load) m_pc = int'(pc_load_val);
                if (fetch_req) begin m_addr = m_pc; m_left = 2; end
            end else begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_ir = 16'hA000 + 16'(m_addr);
                    m_pc = (m_addr + 1) % 128;
                    m_valid = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_live) begin
            chk("model_ir", 32'(ir), 32'(m_ir));
            chk("model_ir_valid", 32'(ir_valid), 32'(m_valid));
            chk("model_pc", 32'(pc), 32'(m_pc));
            chk("model_rom_addr", 32'(rom_addr), 32'(m_pc));
            chk("model_busy", 32'(busy), 32'(m_left != 0));
        end
    end

    task automatic drive(input logic fr, input logic ld, input logic [6:0] v);
        fetch_req = fr; pc_load = ld; pc_load_val = v;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0);
        drive(0, 0, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        @(negedge clock);
        do_reset();
        chk("reset_ir", 32'(ir), 32'h0);
        chk("reset_pc", 32'(pc), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_valid", 32'(ir_valid), 32'h0);

        drive(1, 0, 0);
        chk("single_busy_addr", 32'(busy), 32'h1);
        drive(0, 0, 0);
        chk("single_no_early_valid", 32'(ir_valid), 32'h0);
        drive(0, 0, 0);
        chk("single_valid", 32'(ir_valid), 32'h1);
        chk("single_ir", 32'(ir), 32'hA000);
        chk("single_pc", 32'(pc), 32'h1);
        drive(0, 0, 0);
        chk("single_valid_drop", 32'(ir_valid), 32'h0);

        do_reset();
        for (int j = 1; j <= 12; j++) begin
            drive(1, 0, 0);
            if (j % 3 == 0) begin
                chk("b2b_valid", 32'(ir_valid), 32'h1);
                chk("b2b_ir", 32'(ir), 32'hA000 + 32'(j / 3 - 1));
            end else
                chk("b2b_gap", 32'(ir_valid), 32'h0);
        end
        chk("b2b_pc", 32'(pc), 32'h4);
        drive(0, 0, 0);

        drive(0, 1, 7'h7F);
        chk("load_pc", 32'(pc), 32'h7F);
        drive(1, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
        chk("wrap_ir", 32'(ir), 32'hA07F);
        chk("wrap_pc", 32'(pc), 32'h0);
        drive(1, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
        chk("wrap2_ir", 32'(ir), 32'hA000);
        chk("wrap2_pc", 32'(pc), 32'h1);

        drive(1, 1, 7'h20); drive(0, 0, 0); drive(0, 0, 0);
        chk("ldfetch_ir", 32'(ir), 32'hA020);
        chk("ldfetch_pc", 32'(pc), 32'h21);

        drive(1, 0, 0);
        drive(1, 1, 7'h10);
        chk("busy_pc_hold", 32'(pc), 32'h21);
        drive(0, 1, 7'h10);
        chk("busy_ld_ir", 32'(ir), 32'hA021);
        chk("busy_ld_pc", 32'(pc), 32'h22);
        drive(0, 0, 0);
        chk("busy_req_not_queued", 32'(busy), 32'h0);

        drive(1, 0, 0); drive(0, 0, 0);
        reset_n = 1'b0;
        drive(1, 1, 7'h33);
        reset_n = 1'b1;
        chk("abort_cap_valid", 32'(ir_valid), 32'h0);
        chk("abort_cap_ir", 32'(ir), 32'h0);
        chk("abort_cap_pc", 32'(pc), 32'h0);
        chk("abort_cap_busy", 32'(busy), 32'h0);

        drive(1, 0, 0);
        reset_n = 1'b0;
        drive(0, 0, 0);
        reset_n = 1'b1;
        drive(0, 0, 0);
        chk("abort_addr_valid", 32'(ir_valid), 32'h0);
        chk("abort_addr_busy", 32'(busy), 32'h0);

        for (int i = 0; i < 800; i++) begin
            reset_n = ($urandom_range(59) != 0);
            drive(logic'($urandom_range(2) != 0), logic'($urandom_range(4) == 0),
                  7'($urandom_range(127)));
        end
        reset_n = 1'b1;
        drive(0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule
